// File: rtl/trap_controller_pkg.sv
// Shared definitions for the M-mode trap controller:
// CSR addresses, mcause codes, FSM and event encodings.
package trap_controller_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_MEI     = 5'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_EXC,
    EV_MRET,
    EV_IRQ
  } event_e;

endpackage

// File: rtl/trap_csr_file.sv
// M-mode trap CSR storage, read mux and trap/CSR write priority.
// TRAP_VECTORED_EN makes mtvec.MODE writable and vectors interrupts.
module trap_csr_file
  import trap_controller_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            nrst,
  input  event_e          ev_i,
  input  logic [XLEN-1:0] ev_cause_i,
  input  logic [XLEN-1:0] ev_pc_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_waddr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic [11:0]     csr_raddr_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] trap_pc_o,
  output logic [XLEN-1:0] irq_pc_o,
  output logic            mie_o,
  output logic            meie_o
);

  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
  localparam logic [XLEN-1:0] MTVEC_INIT = MTVEC_RST & ALIGN;

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic            meie_q, meie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] wtvec;

`ifdef TRAP_VECTORED_EN
  assign wtvec = {csr_wdata_i[XLEN-1:2], 1'b0, csr_wdata_i[0]};
`else
  assign wtvec = csr_wdata_i & ALIGN;
`endif

  // Trap updates are applied after the CSR write so they win.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    if (csr_we_i) begin
      unique case (csr_waddr_i)
        CSR_MSTATUS: begin
          mie_d  = csr_wdata_i[MSTATUS_MIE];
          mpie_d = csr_wdata_i[MSTATUS_MPIE];
        end
        CSR_MIE:      meie_d     = csr_wdata_i[MIE_MEIE];
        CSR_MTVEC:    mtvec_d    = wtvec;
        CSR_MSCRATCH: mscratch_d = csr_wdata_i;
        CSR_MEPC:     mepc_d     = csr_wdata_i & ALIGN;
        CSR_MCAUSE:   mcause_d   = csr_wdata_i;
        default: ;
      endcase
    end
    unique case (ev_i)
      EV_EXC, EV_IRQ: begin
        mepc_d   = ev_pc_i & ALIGN;
        mcause_d = ev_cause_i;
        mpie_d   = mie_q;
        mie_d    = 1'b0;
      end
      EV_MRET: begin
        mie_d  = mpie_q;
        mpie_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= MTVEC_INIT;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mscratch_q <= mscratch_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    unique case (csr_raddr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[12:11]          = 2'b11;
        csr_rdata_o[MSTATUS_MPIE]   = mpie_q;
        csr_rdata_o[MSTATUS_MIE]    = mie_q;
      end
      CSR_MIE:      csr_rdata_o[MIE_MEIE] = meie_q;
      CSR_MTVEC:    csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: csr_rdata_o = mscratch_q;
      CSR_MEPC:     csr_rdata_o = mepc_q;
      CSR_MCAUSE:   csr_rdata_o = mcause_q;
      default: ;
    endcase
  end

  assign trap_pc_o = mtvec_q & ALIGN;
`ifdef TRAP_VECTORED_EN
  assign irq_pc_o = mtvec_q[0] ? trap_pc_o + XLEN'(4 * CAUSE_MEI)
                               : trap_pc_o;
`else
  assign irq_pc_o = trap_pc_o;
`endif

  assign mepc_o = mepc_q;
  assign mie_o  = mie_q;
  assign meie_o = meie_q;

endmodule

// File: rtl/trap_controller.sv
// Commit-stage trap consumer: flush then redirect fetch on traps/xRET.
// TRAP_VECTORED_EN enables vectored interrupt dispatch via mtvec.MODE.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] MTVEC_RST    = '0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            exception_pending,
  input  logic [XLEN-1:0] cause,
  input  logic [XLEN-1:0] pc_exc,
  input  logic            mret,
  input  logic            sret,
  input  logic            uret,
  input  logic            csr_we,
  input  logic [11:0]     csr_wb_addr,
  input  logic [XLEN-1:0] csr_wb,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            irq_ext,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  localparam logic [3:0] CNT_LAST = 4'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  event_e          ev;
  logic [XLEN-1:0] ev_cause;
  logic [XLEN-1:0] ev_tgt;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] irq_pc;
  logic            mie;
  logic            meie;

  trap_csr_file #(
    .XLEN      (XLEN),
    .MTVEC_RST (MTVEC_RST)
  ) u_csr (
    .clk         (clk),
    .nrst        (nrst),
    .ev_i        (ev),
    .ev_cause_i  (ev_cause),
    .ev_pc_i     (pc_exc),
    .csr_we_i    (csr_we),
    .csr_waddr_i (csr_wb_addr),
    .csr_wdata_i (csr_wb),
    .csr_raddr_i (csr_raddr),
    .csr_rdata_o (csr_rdata),
    .mepc_o      (mepc),
    .trap_pc_o   (trap_pc),
    .irq_pc_o    (irq_pc),
    .mie_o       (mie),
    .meie_o      (meie)
  );

  // sret/uret have no S/U mode to return to: raise illegal instruction.
  always_comb begin
    ev       = EV_NONE;
    ev_cause = '0;
    ev_tgt   = trap_pc;
    if (state_q == ST_IDLE) begin
      if (exception_pending) begin
        ev       = EV_EXC;
        ev_cause = cause;
      end else if (sret | uret) begin
        ev       = EV_EXC;
        ev_cause = XLEN'(CAUSE_ILLEGAL);
      end else if (mret) begin
        ev     = EV_MRET;
        ev_tgt = mepc;
      end else if (irq_ext & mie & meie) begin
        ev       = EV_IRQ;
        ev_cause = {1'b1, (XLEN-1)'(CAUSE_MEI)};
        ev_tgt   = irq_pc;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tgt_d          = tgt_q;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ev != EV_NONE) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
          tgt_d   = ev_tgt;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_REDIRECT;
        else cnt_d = cnt_q + 4'd1;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign redirect_pc = tgt_q;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller with a behavioural CSR model.
// Honours TRAP_VECTORED_EN for the expected interrupt target.
module tb_trap_controller;

  localparam int XLEN = 32;
  localparam int FC   = 2;
`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        exception_pending = 1'b0;
  logic [31:0] cause = '0;
  logic [31:0] pc_exc = '0;
  logic        mret = 1'b0, sret = 1'b0, uret = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_wb_addr = '0;
  logic [31:0] csr_wb = '0;
  logic [11:0] csr_raddr = '0;
  logic [31:0] csr_rdata;
  logic        irq_ext = 1'b0;
  logic        flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b0;

  always #5 clk = ~clk;

  trap_controller #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (FC),
    .MTVEC_RST    (32'h0)
  ) dut (
    .clk               (clk),
    .nrst              (nrst),
    .exception_pending (exception_pending),
    .cause             (cause),
    .pc_exc            (pc_exc),
    .mret              (mret),
    .sret              (sret),
    .uret              (uret),
    .csr_we            (csr_we),
    .csr_wb_addr       (csr_wb_addr),
    .csr_wb            (csr_wb),
    .csr_raddr         (csr_raddr),
    .csr_rdata         (csr_rdata),
    .irq_ext           (irq_ext),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .redirect_ready    (redirect_ready)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  bit          m_mie, m_mpie, m_meie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return 32'(m_meie) << 11;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_write(logic [11:0] a, logic [31:0] d,
                                  bit keep_st, bit keep_tr);
    case (a)
      12'h300: if (!keep_st) begin m_mie = d[3]; m_mpie = d[7]; end
      12'h304: m_meie = d[11];
      12'h305: m_mtvec = VEC ? (d & 32'hFFFF_FFFD) : (d & 32'hFFFF_FFFC);
      12'h340: m_mscratch = d;
      12'h341: if (!keep_tr) m_mepc = d & 32'hFFFF_FFFC;
      12'h342: if (!keep_tr) m_mcause = d;
      default: ;
    endcase
  endfunction

  task automatic csr_write(logic [11:0] a, logic [31:0] d);
    @(negedge clk);
    csr_we = 1; csr_wb_addr = a; csr_wb = d;
    m_write(a, d, 0, 0);
    @(negedge clk);
    csr_we = 0;
  endtask

  task automatic check_csr(string name, logic [11:0] a);
    @(negedge clk);
    csr_raddr = a;
    #1 chk(name, csr_rdata, m_read(a));
  endtask

  task automatic issue(bit exc, logic [31:0] c, logic [31:0] pc,
                       bit mr, bit sr, bit ur, bit irq,
                       bit we, logic [11:0] wa, logic [31:0] wd,
                       int stall);
    bit ev = 1, t_st = 0, t_tr = 0;
    logic [31:0] base = m_mtvec & 32'hFFFF_FFFC;
    logic [31:0] tgt = base, ncause = 0;
    bit nmie = m_mie, nmpie = m_mpie;
    int st = stall;
    @(negedge clk);
    exception_pending = exc; cause = c; pc_exc = pc;
    mret = mr; sret = sr; uret = ur; irq_ext = irq;
    csr_we = we; csr_wb_addr = wa; csr_wb = wd;
    if (exc || sr || ur) begin
      t_st = 1; t_tr = 1; ncause = exc ? c : 32'd2;
    end else if (mr) begin
      t_st = 1; tgt = m_mepc; nmie = m_mpie; nmpie = 1;
    end else if (irq && m_mie && m_meie) begin
      t_st = 1; t_tr = 1; ncause = 32'h8000_000B;
      tgt = (VEC && m_mtvec[0]) ? base + 32'd44 : base;
    end else ev = 0;
    if (t_tr) begin nmpie = m_mie; nmie = 0; end
    if (we) m_write(wa, wd, t_st, t_tr);
    if (t_tr) begin m_mepc = pc & 32'hFFFF_FFFC; m_mcause = ncause; end
    if (t_st) begin m_mie = nmie; m_mpie = nmpie; end
    if (ev) sb.push_back(tgt);
    csr_we = we;
    if (ev) begin
      for (int i = 0; i < FC; i++) begin
        @(negedge clk);
        csr_we = 0;
        exception_pending = 1'($urandom); mret = 1'($urandom);
        sret = 1'($urandom); uret = 1'($urandom);
        irq_ext = 1'($urandom); cause = $urandom; pc_exc = $urandom;
      end
    end
    @(negedge clk);
    exception_pending = 0; mret = 0; sret = 0; uret = 0;
    irq_ext = 0; csr_we = 0;
    if (ev) begin
      for (int n = 0; n < 60 && sb.size() > 0; n++) begin
        if (st > 0) begin redirect_ready = 0; st--; end
        else redirect_ready = 1;
        @(negedge clk);
      end
      if (sb.size() > 0) begin
        chk("redirect_timeout", 32'(sb.size()), 0);
        sb.delete();
      end
      redirect_ready = 0;
    end else begin
      repeat (3) begin
        @(negedge clk);
        #1 chk("no_event_quiet", {30'b0, flush, redirect_valid}, 0);
      end
    end
  endtask

  int flush_run = 0;
  bit prev_v = 0;

  always @(negedge clk) begin
    #1;
    if (!nrst) begin
      flush_run = 0;
      prev_v = 0;
    end else begin
      if (flush) flush_run++;
      if (redirect_valid) begin
        if (!prev_v) begin
          chk("flush_len", 32'(flush_run), FC);
          flush_run = 0;
        end
        if (sb.size() == 0) chk("spurious_redirect", 32'(redirect_valid), 0);
        else begin
          chk("redirect_pc", redirect_pc, sb[0]);
          if (redirect_ready) void'(sb.pop_front());
        end
      end
      if (flush && redirect_valid) chk("flush_and_valid", 1, 0);
      prev_v = redirect_valid;
    end
  end

  logic [11:0] addrs[7] = '{12'h300, 12'h304, 12'h305, 12'h340,
                            12'h341, 12'h342, 12'h123};

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_flush", 32'(flush), 0);
    chk("rst_valid", 32'(redirect_valid), 0);
    chk("rst_pc", redirect_pc, 0);
    check_csr("rst_mstatus", 12'h300);
    check_csr("rst_mtvec", 12'h305);
    @(negedge clk);
    nrst = 1;

    csr_write(12'h305, 32'h800);
    issue(1, 5, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    check_csr("t1_mepc", 12'h341);
    check_csr("t1_mcause", 12'h342);
    check_csr("t1_mstatus", 12'h300);

    csr_write(12'h300, 32'h80);
    csr_write(12'h341, 32'h200);
    issue(0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    check_csr("t2_mstatus", 12'h300);

    issue(1, 3, 32'h204, 0, 0, 0, 0, 0, 0, 0, 5);
    check_csr("t3_mepc", 12'h341);

    issue(1, 4, 32'h306, 1, 0, 0, 0, 1, 12'h341, 32'hABC, 1);
    check_csr("t4_mepc", 12'h341);
    check_csr("t4_mcause", 12'h342);

    csr_write(12'h305, 32'h801);
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'h800);
    issue(0, 0, 32'h500, 0, 0, 0, 1, 0, 0, 0, 2);
    csr_raddr = 12'h342;
    #1 chk("t5_mcause", csr_rdata, 32'h8000_000B);
    check_csr("t5_mtvec", 12'h305);

    issue(0, 0, 32'h600, 0, 0, 0, 1, 0, 0, 0, 0);
    issue(0, 0, 32'h400, 0, 1, 0, 0, 0, 0, 0, 0);
    check_csr("sret_mcause", 12'h342);

    for (int k = 0; k < 40; k++) begin
      int kind = $urandom_range(0, 5);
      csr_write(addrs[$urandom_range(0, 6)], $urandom);
      check_csr("rnd_csr", addrs[$urandom_range(0, 6)]);
      issue(kind == 0, $urandom, $urandom, kind == 1, kind == 2,
            kind == 3, kind >= 4, 1'($urandom),
            addrs[$urandom_range(0, 6)], $urandom,
            $urandom_range(0, 3));
    end

    @(negedge clk);
    exception_pending = 1; cause = 7; pc_exc = 32'h44;
    @(negedge clk);
    exception_pending = 0;
    #1 chk("t6_in_flush", 32'(flush), 1);
    nrst = 0;
    #1;
    chk("t6_flush", 32'(flush), 0);
    chk("t6_valid", 32'(redirect_valid), 0);
    chk("t6_pc", redirect_pc, 0);
    m_reset();
    sb.delete();
    @(negedge clk);
    nrst = 1;
    repeat (4) begin
      @(negedge clk);
      #1 chk("t6_idle", {30'b0, flush, redirect_valid}, 0);
    end
    check_csr("t6_mepc", 12'h341);
    check_csr("t6_mstatus", 12'h300);
    check_csr("t6_mtvec", 12'h305);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
